// File: rtl/mips_uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package mips_io_pkg;

    // Default bus addresses of the transmit data and status/control registers
    localparam logic [31:0] TX_ADDR_DEFAULT     = 32'h1001_0024;
    localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'h1001_0028;

    // Bit positions inside the status word
    localparam int unsigned STAT_FULL   = 0;
    localparam int unsigned STAT_EMPTY  = 1;
    localparam int unsigned STAT_ACTIVE = 2;
    localparam int unsigned STAT_OVF    = 3;

    // Transmitter frame states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/mips_uart_tx_mmio_if.sv
// Data-memory bus as seen by the UART peripheral.
interface mips_uart_tx_mmio_if;

    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        IOSelect;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData, IOSelect
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData, IOSelect
    );

endinterface

// File: rtl/mips_uart_tx_mmio_fifo.sv
// Synchronous FIFO with a combinational read port (dout shows the head entry).
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks push/pop balance
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: address decode, status register,
// transmit FIFO and baud-rate serializer.
module mips_uart_tx_mmio
    import mips_io_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 434,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] TX_ADDR     = TX_ADDR_DEFAULT,
    parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    mips_uart_tx_mmio_if.slave  bus,
    output logic                TxD,
    output logic                TxBusy
);

    localparam int unsigned     CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(CLK_DIV - 1);

    logic             sel_tx;
    logic             sel_stat;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             ovf_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             overflow;
    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [31:0]      status;
    logic             unused_wdata;

    assign unused_wdata = ^bus.WriteData[31:8];

    assign sel_tx       = (bus.Address == TX_ADDR);
    assign sel_stat     = (bus.Address == STATUS_ADDR);
    assign bus.IOSelect = sel_tx || sel_stat;

    assign push_req  = bus.MemWrite && sel_tx;
    assign push      = push_req && !fifo_full;
    assign ovf_clear = bus.MemWrite && sel_stat && bus.WriteData[STAT_OVF];

    // A new byte is taken whenever the line is free: from IDLE, or at the
    // last cycle of STOP so that queued frames follow with no gap
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));

    assign TxBusy = !fifo_empty || (state != ST_IDLE);

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow: set by a store into a full FIFO, write-1-to-clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Status word, visible only during a load from the status address
    always_comb begin
        status              = '0;
        status[STAT_FULL]   = fifo_full;
        status[STAT_EMPTY]  = fifo_empty;
        status[STAT_ACTIVE] = (state != ST_IDLE);
        status[STAT_OVF]    = overflow;
        bus.ReadData        = (bus.MemRead && sel_stat) ? status : '0;
    end

    // Frame serializer; TxD is registered and changes with each state/bit step
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TxD      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    TxD <= 1'b1;
                    if (pop) begin
                        shift    <= fifo_dout;
                        baud_cnt <= DIV_M1;
                        TxD      <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        bit_idx  <= '0;
                        TxD      <= shift[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == 3'd7) begin
                            TxD   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            TxD     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        if (pop) begin
                            shift    <= fifo_dout;
                            baud_cnt <= DIV_M1;
                            TxD      <= 1'b0;
                            state    <= ST_START;
                        end else begin
                            TxD   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    TxD   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_uart_tx_mmio.sv
// Bench for the UART transmitter: directed scenarios plus random bus traffic,
// checked against a frame-timeline reference model and a serial-line scoreboard.
module tb_mips_uart_tx_mmio;

    localparam int          CD    = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CD;
    localparam logic [31:0] TXA   = 32'h1001_0024;
    localparam logic [31:0] STA   = 32'h1001_0028;

    logic clk = 1'b0;
    logic reset;
    logic TxD;
    logic TxBusy;

    mips_uart_tx_mmio_if bus ();

    mips_uart_tx_mmio #(
        .CLK_DIV     (CD),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TXA),
        .STATUS_ADDR (STA)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .TxD    (TxD),
        .TxBusy (TxBusy)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference model: bytes waiting in the FIFO, cycles left in the frame on
    // the line, sticky overflow, and the bytes expected on the line in order
    int         m_cnt  = 0;
    int         m_left = 0;
    logic       m_ovf  = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] m_status();
        return {28'b0, m_ovf, 1'(m_left > 0), 1'(m_cnt == 0), 1'(m_cnt == DEPTH)};
    endfunction

    function automatic logic m_busy();
        return (m_cnt > 0) || (m_left > 0);
    endfunction

    // One bus cycle: drive, check combinational outputs mid-cycle, then advance the model
    task automatic cyc(input logic rst, input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic re);
        logic full0, pop, push_try;
        reset         = rst;
        bus.Address   = addr;
        bus.WriteData = wd;
        bus.MemWrite  = we;
        bus.MemRead   = re;
        @(negedge clk);
        if (!rst) begin
            chk("iosel", 32'(bus.IOSelect), 32'((addr == TXA) || (addr == STA)));
            chk("busy", 32'(TxBusy), 32'(m_busy()));
            chk("rdata", bus.ReadData, (re && addr == STA) ? m_status() : 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            m_cnt  = 0;
            m_left = 0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            full0    = (m_cnt == DEPTH);
            pop      = (m_cnt > 0) && (m_left <= 1);
            push_try = we && (addr == TXA);
            if (we && addr == STA && wd[3]) m_ovf = 1'b0;
            else if (push_try && full0)      m_ovf = 1'b1;
            if (pop) begin
                m_left = FRAME;
                m_cnt--;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (push_try && !full0) begin
                m_cnt++;
                exp_q.push_back(wd[7:0]);
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wd);
        cyc(1'b0, addr, wd, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [31:0] addr);
        cyc(1'b0, addr, 32'h0, 1'b0, 1'b1);
    endtask

    // Momentary look at the read path between edges
    task automatic peek(input string nm, input logic [31:0] addr, input logic exp_sel,
                        input logic [31:0] exp_rd);
        bus.Address  = addr;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        #1;
        chk({nm, "_iosel"}, 32'(bus.IOSelect), 32'(exp_sel));
        chk({nm, "_rdata"}, bus.ReadData, exp_rd);
    endtask

    task automatic wait_idle(input string nm, input int bound, output int n);
        n = 0;
        while (n < bound) begin
            idle();
            n++;
            if (TxBusy === 1'b0 && !m_busy()) break;
        end
        chk({nm, "_drained"}, 32'(TxBusy), 32'h0);
    endtask

    // Serial-line monitor: every start bit pops the next expected byte and the
    // whole 10-bit frame is checked sample by sample, CD samples per bit
    initial begin
        logic [9:0] f;
        logic       known;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || TxD !== 1'b0) continue;
            known = (exp_q.size() > 0);
            if (known) begin
                f = {1'b1, exp_q.pop_front(), 1'b0};
            end else begin
                total++;
                $display("FAIL frame_unexpected: start bit with no byte queued at %0t", $time);
                f = '0;
            end
            for (int j = 0; j < FRAME; j++) begin
                if (j > 0) @(negedge clk);
                if (reset !== 1'b0) break;
                if (known) chk("frame_bit", 32'(TxD), 32'(f[j / CD]));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         lows;
        int unsigned r;
        logic [31:0] a;

        // Reset and quiet period
        repeat (3) cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (50) idle();
        chk("reset_txd", 32'(TxD), 32'h1);
        chk("reset_busy", 32'(TxBusy), 32'h0);
        peek("reset_status", STA, 1'b1, 32'h0000_0002);

        // Single frame 0x55 with start-bit latency
        store(TXA, 32'hFFFF_FF55);
        chk("latency_pre", 32'(TxD), 32'h1);
        idle();
        chk("latency_fall", 32'(TxD), 32'h0);
        wait_idle("single", 200, n);
        chk("single_len", 32'(n), 32'd40);

        // Back-to-back frames
        store(TXA, 32'h0000_00A5);
        store(TXA, 32'h0000_003C);
        wait_idle("pair", 300, n);
        chk("pair_len", 32'(n), 32'd80);

        // Overflow: one byte on the line, eight queued, tenth dropped
        for (int i = 0; i < 10; i++) store(TXA, 32'(8'h10 + i));
        peek("ovf_status", STA, 1'b1, 32'h0000_000D);
        store(STA, 32'h0000_0008);
        peek("ovf_cleared", STA, 1'b1, 32'h0000_0005);
        wait_idle("ovf", 1000, n);

        // Reset during data bit 3 of 0x52, with a second byte still queued
        store(TXA, 32'h0000_0052);
        store(TXA, 32'h0000_0011);
        repeat (16) idle();
        chk("mid_frame_bit3", 32'(TxD), 32'h0);
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("abort_txd", 32'(TxD), 32'h1);
        chk("abort_busy", 32'(TxBusy), 32'h0);
        peek("abort_status", STA, 1'b1, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (TxD !== 1'b1) lows++;
        end
        chk("abort_no_residual", 32'(lows), 32'h0);

        // Decode: neighbouring address is not ours; loads from TX_ADDR are inert
        store(32'h1001_0020, 32'h0000_0077);
        peek("near_addr", 32'h1001_0020, 1'b0, 32'h0);
        load(TXA);
        peek("tx_load", TXA, 1'b1, 32'h0);
        peek("tx_load_status", STA, 1'b1, 32'h0000_0002);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 399);
            if (r < 48)       store(TXA, $urandom);
            else if (r < 68)  load(STA);
            else if (r < 80)  store(STA, $urandom);
            else if (r < 92)  begin a = $urandom; store(a, $urandom); end
            else if (r < 100) begin a = $urandom; load(a); end
            else if (r < 108) load(TXA);
            else if (r == 399) cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
            else              idle();
        end
        wait_idle("random", 1000, n);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        repeat (5) idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_uart_tx_mmio.md
Name: mips_uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the single-cycle core, in parallel with the data RAM.
- Stores to TX_ADDR push a byte into a small FIFO.
- A baud-rate FSM serializes queued bytes onto TxD as 8N1 frames.
- Loads from STATUS_ADDR return FIFO and transmitter status through the core's write-back mux, selected by IOSelect.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥2.
FIFO_DEPTH, 8, byte entries; power of two, ≥2.
TX_ADDR, 32'h1001_0024, byte address of the transmit data register.
STATUS_ADDR, 32'h1001_0028, byte address of the status/control register.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
Address  input  32  data-bus address (ALU result).
WriteData  input  32  store data; only bits [7:0] are used.
MemWrite  input  1  store strobe, qualified by the clk edge.
MemRead  input  1  load strobe.
ReadData  output  32  status word; 0 unless a status read is active.
IOSelect  output  1  1 when Address equals TX_ADDR or STATUS_ADDR; steers the core's write-back mux.
TxD  output  1  serial line; idles high.
TxBusy  output  1  1 while the FIFO is non-empty or the FSM is not in IDLE.

Behaviour:
- Reset values (synchronous, highest priority):
  - TxD=1, TxBusy=0, FIFO empty with pointers 0, overflow=0, state=IDLE, baud counter=0.
  - Reset mid-frame aborts the frame; TxD=1 from the next edge.
- Address decode is combinational on the full 32-bit address; no partial decode.
  - IOSelect=1 on either address match, regardless of MemRead/MemWrite.
- Push:
  - Condition: MemWrite & Address==TX_ADDR & FIFO not full at the start of the cycle → WriteData[7:0] is written at that edge.
  - If the FIFO is full, the byte is dropped and sticky overflow is set, even if a pop occurs in the same cycle.
- Status register:
  - ReadData = {28'b0, overflow, tx_active, fifo_empty, fifo_full}, driven combinationally when MemRead & Address==STATUS_ADDR; otherwise 0.
  - Store to STATUS_ADDR with WriteData[3]=1 clears overflow (write-1-to-clear). Other bits are ignored.
  - If set and clear coincide, clear wins.
- FIFO:
  - Pointer width is $clog2(FIFO_DEPTH); the occupancy counter is one bit wider.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- FSM states: IDLE, START, DATA, STOP. tx_active = (state != IDLE).
  - IDLE: TxD=1. If the FIFO is non-empty: pop into the shift register, load the baud counter with CLK_DIV-1, go to START.
  - START: TxD=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: TxD=shift[0], LSB first. Each bit lasts CLK_DIV cycles. After bit 7 go to STOP.
  - STOP: TxD=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - Baud counter counts down; bit advance happens in the cycle where counter==0.
  - Frame length is exactly 10*CLK_DIV cycles.
- Latency: a store at edge N with IDLE and an empty FIFO causes a pop at edge N+1; TxD falls after edge N+1.
- The FIFO is unaffected by loads to TX_ADDR. ReadData=0 for TX_ADDR loads.

Decomposition:
- Package mips_io_pkg holds:
  - TX_ADDR and STATUS_ADDR defaults.
  - Status bit indices: STAT_FULL=0, STAT_EMPTY=1, STAT_ACTIVE=2, STAT_OVF=3.
  - The UART state encoding enum.
- Sub-module uart_tx_fifo: a synchronous FIFO parameterized by width and depth, with push, pop, full, empty and dout outputs.
- Decode, status logic and the FSM stay in the top module.

Test Plan:
- Reset, then no activity for 50 cycles → TxD=1, TxBusy=0; status read returns 32'h0000_0002.
- CLK_DIV=4; store 32'hFFFF_FF55 to TX_ADDR → TxD falls one cycle after the store edge; line pattern is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total; then TxBusy=0.
- CLK_DIV=4; store 0xA5 then 0x3C on consecutive cycles → two frames with no gap; STOP of the first frame is followed directly by START of the second; 80 cycles total.
- FIFO_DEPTH=8; store 10 bytes back-to-back while the first frame is in flight → 1 popped plus 8 queued; the 10th store is dropped; status reads 32'h0000_000D; then store 32'h8 to STATUS_ADDR → overflow bit clears.
- Assert reset during DATA bit 3 of a frame → TxD=1 next cycle, FIFO empty, status 32'h0000_0002; no residual frame is sent after reset releases.
- Store to 32'h1001_0020 and load from TX_ADDR → IOSelect=0 for the first and 1 for the second; FIFO unchanged; ReadData=0.
